// File: rtl/rvseq_pkg.sv
// Shared types and constants for the RISC-V test sequencer.
package rvseq_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int IMEM_STRIDE = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_I,
    S_LOAD_D,
    S_RUN,
    S_CHECK,
    S_DONE
  } state_t;

  // clog2 with a floor of one bit
  function automatic int clog2m1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/riscv_test_sequencer_if.sv
// Core-side bus of the test sequencer: memory load ports,
// run control and register-file debug read.
interface riscv_test_sequencer_if #(
  parameter int XLEN = rvseq_pkg::XLEN
);

  logic            imem_we;
  logic [31:0]     imem_addr;
  logic [31:0]     imem_wdata;
  logic            dmem_we;
  logic [31:0]     dmem_addr;
  logic [7:0]      dmem_wdata;
  logic            core_hold;
  logic [31:0]     core_pc;
  logic [4:0]      rf_raddr;
  logic [XLEN-1:0] rf_rdata;

  modport master (
    output imem_we, imem_addr, imem_wdata,
    output dmem_we, dmem_addr, dmem_wdata,
    output core_hold, rf_raddr,
    input  core_pc, rf_rdata
  );

  modport slave (
    input  imem_we, imem_addr, imem_wdata,
    input  dmem_we, dmem_addr, dmem_wdata,
    input  core_hold, rf_raddr,
    output core_pc, rf_rdata
  );

endinterface

// File: rtl/rvseq_checker.sv
// Register-file result checker: x0 reads as zero,
// saturating mismatch count and first failing index.
module rvseq_checker #(
  parameter int XLEN     = 32,
  parameter int N_CHECKS = 8,
  parameter int CW       = 3,
  parameter int FW       = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            en,
  input  logic [CW-1:0]   idx,
  input  logic [4:0]      chk_reg,
  input  logic [XLEN-1:0] chk_val,
  input  logic [XLEN-1:0] rf_rdata,
  output logic [FW-1:0]   fail_count,
  output logic [CW-1:0]   fail_idx
);

  logic [XLEN-1:0] got;
  logic            miss;

  assign got  = (chk_reg == 5'd0) ? '0 : rf_rdata;
  assign miss = en && (got != chk_val);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      fail_count <= '0;
      fail_idx   <= '0;
    end else if (miss) begin
      if (fail_count == '0)
        fail_idx <= idx;
      if (fail_count != FW'(N_CHECKS))
        fail_count <= fail_count + 1'b1;
    end
  end

endmodule

// File: rtl/riscv_test_sequencer.sv
// Load / run / check harness for the single-cycle core.
// Optional RVSEQ_HALT_DETECT_EN ends RUN on a PC self-loop.
module riscv_test_sequencer
  import rvseq_pkg::*;
#(
  parameter int XLEN       = rvseq_pkg::XLEN,
  parameter int PROG_WORDS = 8,
  parameter int DATA_BYTES = 4,
  parameter int N_CHECKS   = 8,
  parameter int RUN_CYCLES = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic done,
  output logic pass,
  output logic halted,
  output logic [clog2m1(N_CHECKS+1)-1:0]   fail_count,
  output logic [clog2m1(N_CHECKS)-1:0]     fail_idx,
  output logic [clog2m1(RUN_CYCLES+1)-1:0] cycles_run,
  output logic [clog2m1(PROG_WORDS)-1:0]   prog_addr,
  input  logic [31:0]                      prog_data,
  output logic [clog2m1(DATA_BYTES)-1:0]   data_addr,
  input  logic [7:0]                       data_val,
  output logic [clog2m1(N_CHECKS)-1:0]     chk_addr,
  input  logic [4:0]                       chk_reg,
  input  logic [XLEN-1:0]                  chk_val,
  riscv_test_sequencer_if.master           bus
);

  localparam int PW  = clog2m1(PROG_WORDS);
  localparam int DW  = clog2m1(DATA_BYTES);
  localparam int CW  = clog2m1(N_CHECKS);
  localparam int FW  = clog2m1(N_CHECKS+1);
  localparam int RW  = clog2m1(RUN_CYCLES+1);
  localparam int PDW = (PW > DW) ? PW : DW;
  localparam int IW  = (PDW > CW) ? PDW : CW;

  state_t        state;
  logic [IW-1:0] idx;
  logic          accept;
  logic          in_load_i;
  logic          in_load_d;
  logic          in_run;
  logic          in_check;
  logic          last_i;
  logic          last_d;
  logic          last_r;
  logic          last_c;
  logic          halt_hit;

  assign in_load_i = (state == S_LOAD_I);
  assign in_load_d = (state == S_LOAD_D);
  assign in_run    = (state == S_RUN);
  assign in_check  = (state == S_CHECK);
  assign accept    = start &&
                     (state == S_IDLE || state == S_DONE);

  assign last_i = (idx == IW'(PROG_WORDS-1));
  assign last_d = (idx == IW'(DATA_BYTES-1));
  assign last_c = (idx == IW'(N_CHECKS-1));
  assign last_r = (cycles_run == RW'(RUN_CYCLES-1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      idx        <= '0;
      cycles_run <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            state      <= S_LOAD_I;
            idx        <= '0;
            cycles_run <= '0;
          end
        end
        S_LOAD_I: begin
          if (last_i) begin
            state <= S_LOAD_D;
            idx   <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_LOAD_D: begin
          if (last_d) begin
            state <= S_RUN;
            idx   <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_RUN: begin
          cycles_run <= cycles_run + 1'b1;
          if (last_r || halt_hit) begin
            state <= S_CHECK;
            idx   <= '0;
          end
        end
        S_CHECK: begin
          if (last_c) begin
            state <= S_DONE;
            idx   <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

`ifdef RVSEQ_HALT_DETECT_EN
  logic [31:0] prev_pc;
  logic        pc_valid;
  logic        halted_q;

  // pc_valid keeps the first RUN cycle from matching a stale PC
  assign halt_hit = in_run && pc_valid &&
                    (bus.core_pc == prev_pc);

  always_ff @(posedge clk) begin
    if (reset || accept) begin
      prev_pc  <= '0;
      pc_valid <= 1'b0;
      halted_q <= 1'b0;
    end else if (in_run) begin
      prev_pc  <= bus.core_pc;
      pc_valid <= 1'b1;
      if (halt_hit)
        halted_q <= 1'b1;
    end
  end

  assign halted = halted_q;
`else
  logic unused_pc;

  assign unused_pc = ^bus.core_pc;
  assign halt_hit  = 1'b0;
  assign halted    = 1'b0;
`endif

  assign prog_addr = idx[PW-1:0];
  assign data_addr = idx[DW-1:0];
  assign chk_addr  = idx[CW-1:0];

  assign busy = in_load_i || in_load_d || in_run || in_check;
  assign done = (state == S_DONE);
  assign pass = done && (fail_count == '0);

  assign bus.imem_we    = in_load_i;
  assign bus.imem_addr  = in_load_i ?
                          32'(prog_addr) * IMEM_STRIDE : '0;
  assign bus.imem_wdata = in_load_i ? prog_data : '0;
  assign bus.dmem_we    = in_load_d;
  assign bus.dmem_addr  = in_load_d ? 32'(data_addr) : '0;
  assign bus.dmem_wdata = in_load_d ? data_val : '0;
  assign bus.core_hold  = !in_run;
  assign bus.rf_raddr   = in_check ? chk_reg : '0;

  rvseq_checker #(
    .XLEN     (XLEN),
    .N_CHECKS (N_CHECKS),
    .CW       (CW),
    .FW       (FW)
  ) u_chk (
    .clk        (clk),
    .reset      (reset),
    .clear      (accept),
    .en         (in_check),
    .idx        (chk_addr),
    .chk_reg    (chk_reg),
    .chk_val    (chk_val),
    .rf_rdata   (bus.rf_rdata),
    .fail_count (fail_count),
    .fail_idx   (fail_idx)
  );

endmodule
